// File: rtl/rx_dsp_pkg.sv
// rtl/rx_dsp_pkg.sv - shared constants and state encoding for the rx dsp blocks
package rx_dsp_pkg;
    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_FRAC_BITS = 15;
    localparam int Q15_MAX       = 32767;
    localparam int Q15_MIN       = -32768;
    localparam int DIV_ITERS     = 15;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        SUM,
        DIV,
        DONE
    } state_t;
endpackage

// File: rtl/udiv_iter_q15.sv
// rtl/udiv_iter_q15.sv - restoring unsigned divider, one quotient bit per step
module udiv_iter_q15 #(
    parameter int RW = 33,
    parameter int MW = 32,
    parameter int QW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [RW-1:0] dividend,
    input  logic [MW-1:0] divisor,
    output logic [QW-1:0] quo_next
);
    logic [RW-1:0] rem;
    logic [QW-1:0] quo;
    logic [RW:0]   rem_sh;
    logic [RW-1:0] rem_next;
    logic          take;

    // One bit of headroom on the shifted remainder keeps the compare exact.
    always_comb begin
        rem_sh   = {rem, 1'b0};
        take     = rem_sh >= (RW+1)'(divisor);
        rem_next = take ? RW'(rem_sh - (RW+1)'(divisor)) : RW'(rem_sh);
        quo_next = {quo[QW-2:0], take};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
        end else if (start) begin
            rem <= dividend;
            quo <= '0;
        end else if (step) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end
endmodule

// File: rtl/complex_div_q15.sv
// rtl/complex_div_q15.sv - iterative Q0.15 complex divider, q = num*conj(den)/|den|^2
module complex_div_q15
    import rx_dsp_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] num_re,
    input  logic [DATAWIDTH-1:0] num_im,
    input  logic [DATAWIDTH-1:0] den_re,
    input  logic [DATAWIDTH-1:0] den_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] q_re,
    output logic [DATAWIDTH-1:0] q_im,
    output logic                 sat,
    output logic                 div0
);
    localparam int PW = 2 * DATAWIDTH;
    localparam int SW = PW + 1;
    localparam int CW = $clog2(DIV_ITERS);

    state_t                      state, state_next;
    logic        [CW-1:0]        cnt;
    logic signed [DATAWIDTH-1:0] nr, ni, dr, di;
    logic signed [PW-1:0]        p_rr, p_ii, p_ir, p_ri, dr_sq, di_sq;
    logic signed [SW-1:0]        p_re, p_im;
    logic        [SW-1:0]        abs_re, abs_im;
    logic        [PW-1:0]        m_sum, m;
    logic                        neg_re, neg_im, ovf_re, ovf_im;
    logic        [FRAC_BITS-1:0] qn_re, qn_im;
    logic                        last;

    function automatic logic [DATAWIDTH-1:0] resolve(input logic zero, input logic ovf,
                                                     input logic neg, input logic [FRAC_BITS-1:0] mag);
        logic [DATAWIDTH-1:0] ext;
        ext = DATAWIDTH'(mag);
        if (zero)
            resolve = '0;
        else if (ovf)
            resolve = neg ? DATAWIDTH'(Q15_MIN) : DATAWIDTH'(Q15_MAX);
        else
            resolve = neg ? -ext : ext;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (state == DIV) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = MUL;
            MUL:     state_next = SUM;
            SUM:     state_next = DIV;
            DIV:     if (cnt == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Cross terms of num*conj(den) and the squared magnitude of den.
    always_comb begin
        p_re   = SW'(p_rr) + SW'(p_ii);
        p_im   = SW'(p_ir) - SW'(p_ri);
        abs_re = p_re[SW-1] ? $unsigned(-p_re) : $unsigned(p_re);
        abs_im = p_im[SW-1] ? $unsigned(-p_im) : $unsigned(p_im);
        dr_sq  = PW'(dr) * PW'(dr);
        di_sq  = PW'(di) * PW'(di);
        m_sum  = $unsigned(dr_sq) + $unsigned(di_sq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nr <= '0; ni <= '0; dr <= '0; di <= '0;
            p_rr <= '0; p_ii <= '0; p_ir <= '0; p_ri <= '0;
            m <= '0; neg_re <= 1'b0; neg_im <= 1'b0; ovf_re <= 1'b0; ovf_im <= 1'b0;
            cnt <= '0;
            q_re <= '0; q_im <= '0; sat <= 1'b0; div0 <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                nr <= num_re; ni <= num_im; dr <= den_re; di <= den_im;
            end
            if (state == MUL) begin
                p_rr <= PW'(nr) * PW'(dr);
                p_ii <= PW'(ni) * PW'(di);
                p_ir <= PW'(ni) * PW'(dr);
                p_ri <= PW'(nr) * PW'(di);
            end
            if (state == SUM) begin
                m      <= m_sum;
                neg_re <= p_re[SW-1];
                neg_im <= p_im[SW-1];
                ovf_re <= (m_sum != '0) && (abs_re >= SW'(m_sum));
                ovf_im <= (m_sum != '0) && (abs_im >= SW'(m_sum));
                cnt    <= CW'(DIV_ITERS - 1);
            end else if (state == DIV) begin
                cnt <= cnt - 1'b1;
            end
            // The final quotient bit is taken straight from the dividers' next value.
            if (last) begin
                q_re <= resolve(m == '0, ovf_re, neg_re, qn_re);
                q_im <= resolve(m == '0, ovf_im, neg_im, qn_im);
                sat  <= (m != '0) && (ovf_re || ovf_im);
                div0 <= (m == '0);
            end
        end
    end

    udiv_iter_q15 #(.RW(SW), .MW(PW), .QW(FRAC_BITS)) u_div_re (
        .clk      (clk),
        .rst      (rst),
        .start    (state == SUM),
        .step     (state == DIV),
        .dividend (abs_re),
        .divisor  (m),
        .quo_next (qn_re)
    );

    udiv_iter_q15 #(.RW(SW), .MW(PW), .QW(FRAC_BITS)) u_div_im (
        .clk      (clk),
        .rst      (rst),
        .start    (state == SUM),
        .step     (state == DIV),
        .dividend (abs_im),
        .divisor  (m),
        .quo_next (qn_im)
    );
endmodule

// File: doc/complex_div_q15.md
# complex_div_q15

Iterative complex divider for Q0.15 samples: computes q = num / den = num·conj(den) / |den|² with truncation toward zero and saturation to Q0.15. It is the inverse of the pipelined complex multiplier and is used on the RX path as a one-tap channel equaliser: received sample divided by channel estimate. It uses a valid/ready handshake on both sides and accepts one operation at a time.

## Interface
- DATAWIDTH, 16: sample component width (signed).
- FRAC_BITS, 15: fractional bits of the input and output format.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; reset value 1.
- num_re, num_im  in  DATAWIDTH  numerator, signed Q0.15.
- den_re, den_im  in  DATAWIDTH  denominator, signed Q0.15.
- out_valid  out  1  result valid; reset value 0.
- out_ready  in  1  downstream accepts result.
- q_re, q_im  out  DATAWIDTH  quotient, signed Q0.15; reset value 0.
- sat  out  1  at least one component saturated; reset value 0.
- div0  out  1  den was 0+0j; reset value 0.

## Operation
- FSM states: IDLE, MUL, SUM, DIV, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid & in_ready, register the operands, then go to MUL.
- MUL: register the four 32-bit products nr·dr, ni·di, ni·dr, nr·di. Go to SUM.
- SUM, with P_re = nr·dr + ni·di, P_im = ni·dr − nr·di (33-bit signed) and M = dr² + di² (32-bit unsigned, max 2^31):
  - Register |P_re|, |P_im|, their signs and M.
  - Per component, ovf = (M≠0) & (|P| ≥ M).
  - Load counter with 14. Go to DIV.
- DIV: two parallel restoring dividers, one bit per cycle, 15 iterations.
  - Each iteration: r ← r<<1 (33-bit remainder); if r ≥ M then r ← r − M and the quotient bit is 1.
  - After the iteration with counter==0, go to DONE.
- Result per component, decided at the DIV→DONE edge:
  - M==0: value 0, div0=1.
  - ovf: 32767 if P positive, −32768 if P negative; sat=1.
  - Otherwise: ±q_mag (15-bit magnitude), negated if P is negative. This truncates toward zero.
  - P==0 always gives 0.
- DONE: out_valid=1. q_re, q_im, sat and div0 hold stable while out_valid & !out_ready. On out_ready go to IDLE and drop out_valid.
- Overflow and div0 cases still run all 15 DIV cycles, so latency is constant.
- rst at any time, including mid-DIV or in DONE, immediately returns the block to IDLE with all outputs at their reset values. The operation in progress is discarded.

## Timing
- Acceptance edge T. MUL→SUM at edge T+1, SUM→DIV at edge T+2, DIV iterations at edges T+3..T+17. out_valid is high from edge T+17.
- Latency is 17 cycles, independent of data.
- With out_ready held at 1: handshake at edge T+18, IDLE from T+18, next acceptance possible at edge T+19. Peak throughput is 1 operation per 19 cycles.
- in_valid asserted outside IDLE is ignored; the operands are not captured.
- in_ready never depends combinationally on in_valid. There is no combinational path from any input to any output.

## Structure
- Shared package or header rx_dsp_pkg holds: DATAWIDTH and FRAC_BITS defaults, Q15_MAX=32767, Q15_MIN=−32768, FSM state encodings, DIV_ITERS=15.
- One sub-module, udiv_iter_q15, is instantiated twice (re, im). It owns:
  - the remainder and quotient registers;
  - a start/step interface;
  - the 33-bit compare/subtract.
- The top level owns the FSM, products, sign handling, saturation and the handshake.

## Test plan
- num=(8192,0), den=(16384,0) -> q=(16384,0), sat=0, div0=0, out_valid exactly 17 cycles after acceptance.
- num=(8192,8192), den=(0,16384) -> q=(16384,−16384). num=(0,8192), den=(0,16384) -> q=(16384,0).
- Truncation toward zero: num=(1,0), den=(3,0) -> q=(10922,0). num=(−1,0), den=(3,0) -> q=(−10922,0).
- Saturation and div0:
  - num=(16384,0), den=(8192,0) -> (32767,0), sat=1.
  - num=(−16384,0), den=(8192,0) -> (−32768,0), sat=1.
  - den=(0,0), any num -> (0,0), div0=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. A concurrent in_valid is not captured.
- Reset mid-operation: assert rst at DIV iteration 7 -> out_valid=0, in_ready=1, q=(0,0). A new operation then completes correctly with 17-cycle latency.
